// File: rtl/sram_mem_ctrl_if.sv
// CPU MEM-stage request and asynchronous 16-bit SRAM bus bundle for sram_mem_ctrl.
// slave = controller side, master = pipeline plus SRAM device side.
interface sram_mem_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic               addr_err;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport slave (
    input  wr_en, rd_en, address, wdata, sram_dq_in,
    output rdata, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output wr_en, rd_en, address, wdata, sram_dq_in,
    input  rdata, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage access sequencer: moves one 32-bit word as two 16-bit SRAM halves with WAIT_CYCLES each.
// Optional feature macro SRAM_ADDR_CHECK_EN: out-of-range accesses skip the SRAM and raise addr_err.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input logic            clk,
  input logic            rst,
  sram_mem_ctrl_if.slave bus
);

  localparam int              CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0]     BASE     = 32'(BASE_ADDR);
  localparam int              IW       = SRAM_AW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Word index inside the SRAM; the modulo wrap falls out of the truncation.
  function automatic logic [IW-1:0] word_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[IW+1:2];
  endfunction

`ifdef SRAM_ADDR_CHECK_EN
  function automatic logic out_of_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a < BASE) || ((off >> 2) >= (32'd1 << IW));
  endfunction
`endif

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               op_wr_r, op_wr_s;
  logic [IW-1:0]      idx_r, idx_s;
  logic [31:0]        wdata_r, wdata_s;
  logic [31:0]        rdata_r, rdata_s;
  logic               addr_err_r, addr_err_s;
  logic [SRAM_AW-1:0] sram_addr_r, sram_addr_s;
  logic [15:0]        dq_out_r, dq_out_s;
  logic               dq_oe_r, dq_oe_s;
  logic               we_n_r, we_n_s;
  logic               oe_n_r, oe_n_s;
  logic               req_s;
  logic               ready_s;

  assign req_s = bus.wr_en | bus.rd_en;

  // State register and registered SRAM bus; reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      op_wr_r     <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      addr_err_r  <= 1'b0;
      sram_addr_r <= '0;
      dq_out_r    <= 16'd0;
      dq_oe_r     <= 1'b0;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      op_wr_r     <= op_wr_s;
      idx_r       <= idx_s;
      wdata_r     <= wdata_s;
      rdata_r     <= rdata_s;
      addr_err_r  <= addr_err_s;
      sram_addr_r <= sram_addr_s;
      dq_out_r    <= dq_out_s;
      dq_oe_r     <= dq_oe_s;
      we_n_r      <= we_n_s;
      oe_n_r      <= oe_n_s;
    end
  end

  // Next-state, latched request and read-data capture.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    op_wr_s    = op_wr_r;
    idx_s      = idx_r;
    wdata_s    = wdata_r;
    rdata_s    = rdata_r;
    addr_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          op_wr_s = bus.wr_en;
          idx_s   = word_index(bus.address);
          wdata_s = bus.wdata;
          cnt_s   = '0;
`ifdef SRAM_ADDR_CHECK_EN
          if (out_of_range(bus.address)) begin
            state_s    = DONE;
            addr_err_s = 1'b1;
            if (!bus.wr_en) begin
              rdata_s = 32'd0;
            end else begin
              rdata_s = rdata_r;
            end
          end else begin
            state_s = LO;
          end
`else
          state_s = LO;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = '0;
          state_s = HI;
          if (!op_wr_r) begin
            rdata_s[15:0] = bus.sram_dq_in;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HI: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = '0;
          state_s = DONE;
          if (!op_wr_r) begin
            rdata_s[31:16] = bus.sram_dq_in;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // SRAM bus values for the state being entered, so they line up with the state register.
  always_comb begin
    sram_addr_s = sram_addr_r;
    dq_out_s    = dq_out_r;
    dq_oe_s     = 1'b0;
    we_n_s      = 1'b1;
    oe_n_s      = 1'b1;
    case (state_s)
      LO: begin
        sram_addr_s = {idx_s, 1'b0};
        if (op_wr_s) begin
          dq_out_s = wdata_s[15:0];
          dq_oe_s  = 1'b1;
          we_n_s   = 1'b0;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      HI: begin
        sram_addr_s = {idx_s, 1'b1};
        if (op_wr_s) begin
          dq_out_s = wdata_s[31:16];
          dq_oe_s  = 1'b1;
          we_n_s   = 1'b0;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      default: begin
        sram_addr_s = sram_addr_r;
      end
    endcase
  end

  // ready is combinational in IDLE so a fresh request freezes the pipeline in its own cycle.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = ~req_s;
      DONE:    ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  assign bus.ready       = ready_s;
  assign bus.rdata       = rdata_r;
  assign bus.sram_addr   = sram_addr_r;
  assign bus.sram_dq_out = dq_out_r;
  assign bus.sram_dq_oe  = dq_oe_r;
  assign bus.sram_we_n   = we_n_r;
  assign bus.sram_oe_n   = oe_n_r;
`ifdef SRAM_ADDR_CHECK_EN
  assign bus.addr_err    = addr_err_r;
`else
  assign bus.addr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: directed cases plus random loads/stores against a word-level model.
module tb_sram_mem_ctrl;

  localparam int          W    = 5;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sram_mem_ctrl_if #(.SRAM_AW(AW)) bus ();

  sram_mem_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (1024),
    .SRAM_AW    (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External asynchronous SRAM device
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  end
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'hA5A5 : sram_mem[bus.sram_addr];

  // Word-level reference: key = SRAM word number, value = stored 32-bit word
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rdata;
  logic [31:0] written_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] low_half_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ((off >> 2) * 32'd2) % (32'd1 << AW);
  endfunction

  function automatic bit is_out_of_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a < BASE) || ((off >> 2) >= (32'd1 << (AW - 1)));
  endfunction

  // One full access starting in an IDLE cycle; inputs are scrambled mid-access to prove latching.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    bit          is_wr;
    bit          err;
    logic [31:0] lo;
    logic [31:0] key;
    logic [31:0] exp_half;
    is_wr = wr;
    lo    = low_half_addr(addr);
    key   = lo >> 1;
    err   = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    err   = is_out_of_range(addr);
`endif
    @(negedge clk);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.address = addr;
    bus.wdata   = data;
    #1;
    chk("ready_req_cycle", bus.ready, 1'b0);
    if (err) begin
      @(negedge clk);
      chk("err_ready", bus.ready, 1'b1);
      chk("err_flag", bus.addr_err, 1'b1);
      chk("err_we_n", bus.sram_we_n, 1'b1);
      chk("err_oe_n", bus.sram_oe_n, 1'b1);
      if (!is_wr) exp_rdata = 32'd0;
      chk("err_rdata", bus.rdata, exp_rdata);
    end else begin
      for (int k = 1; k <= 2 * W; k++) begin
        @(negedge clk);
        if (k == 1) begin
          bus.wr_en   = 1'($urandom_range(0, 1));
          bus.rd_en   = 1'($urandom_range(0, 1));
          bus.address = $urandom;
          bus.wdata   = $urandom;
        end
        exp_half = (k <= W) ? {16'd0, data[15:0]} : {16'd0, data[31:16]};
        chk("busy_ready", bus.ready, 1'b0);
        chk("sram_addr", {14'd0, bus.sram_addr}, (k <= W) ? lo : lo + 32'd1);
        chk("we_n", bus.sram_we_n, is_wr ? 1'b0 : 1'b1);
        chk("oe_n", bus.sram_oe_n, is_wr ? 1'b1 : 1'b0);
        chk("dq_oe", bus.sram_dq_oe, is_wr);
        if (is_wr) chk("dq_out", {16'd0, bus.sram_dq_out}, exp_half);
      end
      @(negedge clk);
      if (is_wr) begin
        ref_mem[key] = data;
        written_q.push_back(addr);
      end else begin
        exp_rdata = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
      end
      chk("done_ready", bus.ready, 1'b1);
      chk("done_we_n", bus.sram_we_n, 1'b1);
      chk("done_oe_n", bus.sram_oe_n, 1'b1);
      chk("done_dq_oe", bus.sram_dq_oe, 1'b0);
      chk("done_addr_err", bus.addr_err, 1'b0);
      chk("done_rdata", bus.rdata, exp_rdata);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    n_assert    = 0;
    n_fail      = 0;
    exp_rdata   = 32'd0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.address = 32'd0;
    bus.wdata   = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_we_n", bus.sram_we_n, 1'b1);
    chk("rst_oe_n", bus.sram_oe_n, 1'b1);
    chk("rst_dq_oe", bus.sram_dq_oe, 1'b0);
    chk("rst_addr", {14'd0, bus.sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, bus.sram_dq_out}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_addr_err", bus.addr_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.ready, 1'b1);

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1032, 32'h12345678);
    access(1'b0, 1'b1, 32'd1032, 32'h0);
    chk("t3_rdata", bus.rdata, 32'h12345678);
    access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'd1030, 32'h0);
    chk("t4_rdata", bus.rdata, 32'hCAFEF00D);

    // Reset in the third HI cycle of a write to a word that is never read back
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.address = BASE + 32'd2048;
    bus.wdata   = $urandom;
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("pre_rst_we_n", bus.sram_we_n, 1'b0);
    chk("pre_rst_addr", {14'd0, bus.sram_addr}, 32'd1025);
    rst = 1'b1;
    #1;
    chk("midrst_we_n", bus.sram_we_n, 1'b1);
    chk("midrst_dq_oe", bus.sram_dq_oe, 1'b0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_ready", bus.ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'd0;
    #1;
    chk("postrst_ready", bus.ready, 1'b1);
    chk("postrst_addr", {14'd0, bus.sram_addr}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = BASE + {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        d = $urandom;
        access(1'b1, 1'($urandom_range(0, 1)), a, d);
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        a = {a[31:2], 2'($urandom_range(0, 3))};
        access(1'b0, 1'b1, a, 32'h0);
      end
    end

    // Below BASE: rejected with the check, wraps to the top of SRAM without it
    access(1'b1, 1'b0, 32'h10, 32'h0BADF00D);
    access(1'b0, 1'b1, 32'h10, 32'h0);
`ifdef SRAM_ADDR_CHECK_EN
    chk("t6_rdata", bus.rdata, 32'd0);
`else
    chk("t6_wrap_rdata", bus.rdata, 32'h0BADF00D);
`endif
    @(negedge clk);
    chk("final_ready", bus.ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
